// File: rtl/alarm_seq_ctrl_if.sv
// alarm_seq_ctrl_if: time, setpoint and button inputs plus status outputs
// of the alarm sequencer. The slave modport is the sequencer's view; the
// master modport is the view of the timekeeping/UI side that drives it.
interface alarm_seq_ctrl_if;
   logic       tick_1hz;
   logic [5:0] hrs;
   logic [5:0] mins;
   logic [5:0] secs;
   logic [5:0] alarm_hrs;
   logic [5:0] alarm_mins;
   logic       arm;
   logic       stop_btn;
   logic       snooze_btn;
   logic       ringing;
   logic       buzzer;
   logic       snoozing;
   logic [2:0] snooze_left;
   logic [2:0] state;

   modport master (
      output tick_1hz, hrs, mins, secs, alarm_hrs, alarm_mins,
             arm, stop_btn, snooze_btn,
      input  ringing, buzzer, snoozing, snooze_left, state
   );

   modport slave (
      input  tick_1hz, hrs, mins, secs, alarm_hrs, alarm_mins,
             arm, stop_btn, snooze_btn,
      output ringing, buzzer, snoozing, snooze_left, state
   );
endinterface

// File: rtl/alarm_seq_ctrl.sv
// alarm_seq_ctrl: alarm event sequencer (IDLE/ARMED/RINGING/SNOOZE/DONE).
// Optional feature macro: ALARM_SNOOZE_EN. When undefined, the SNOOZE state
// and all snooze handling are left out, snooze_btn is ignored and the
// snoozing/snooze_left outputs are tied to zero.
// One 16-bit saturating second counter serves both the ring timeout and the
// snooze interval, since the two are never active at the same time.
module alarm_seq_ctrl #(
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic            clk,
   input  logic            reset,
   alarm_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_RINGING = 3'd2,
      ST_SNOOZE  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Counter value seen on the tick that completes the interval
   localparam logic [15:0] RING_LAST   = 16'(RING_TIMEOUT_S - 1);
   localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_MIN * 60 - 1);
   localparam logic [2:0]  SNOOZE_LOAD = 3'(MAX_SNOOZE);

   state_t      r_state;
   logic        r_stop_d;
   logic        r_beep;
   logic [15:0] r_cnt;
   logic [2:0]  r_left;
   logic        r_ringing;
   logic        r_buzzer;

   state_t      w_state_nxt;
   logic        w_beep_nxt;
   logic [15:0] w_cnt_nxt;
   logic [15:0] w_cnt_inc;
   logic [2:0]  w_left_nxt;
   logic        w_stop_edge;
   logic        w_match;
   logic        w_unused;

`ifdef ALARM_SNOOZE_EN
   logic        r_snooze_d;
   logic        r_snoozing;
   logic        w_snooze_edge;

   assign w_snooze_edge    = bus.snooze_btn & ~r_snooze_d;
   assign bus.snoozing     = r_snoozing;
   assign bus.snooze_left  = r_left;
   // Seconds never qualify the match; only hours and minutes do
   assign w_unused         = ^bus.secs;
`else
   assign bus.snoozing     = 1'b0;
   assign bus.snooze_left  = 3'd0;
   assign w_unused         = ^{bus.secs, bus.snooze_btn, SNOOZE_LAST, r_left};
`endif

   assign w_stop_edge = bus.stop_btn & ~r_stop_d;
   assign w_match     = (bus.hrs == bus.alarm_hrs) && (bus.mins == bus.alarm_mins);
   assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

   assign bus.state   = r_state;
   assign bus.ringing = r_ringing;
   assign bus.buzzer  = r_buzzer;

   // Next-state and counter/beep/snooze bookkeeping; arm=0 overrides every event
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_left_nxt  = r_left;
      w_beep_nxt  = r_beep;
      if (!bus.arm) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 16'd0;
         w_left_nxt  = 3'd0;
         w_beep_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
               if (bus.tick_1hz && w_match) begin
                  w_state_nxt = ST_RINGING;
                  w_left_nxt  = SNOOZE_LOAD;
                  w_cnt_nxt   = 16'd0;
                  w_beep_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_ARMED;
               end
            end
            ST_RINGING: begin
               // Stop beats snooze; a user snooze beats a timeout on the same tick
               if (w_stop_edge) begin
                  w_state_nxt = ST_DONE;
               end
`ifdef ALARM_SNOOZE_EN
               else if (w_snooze_edge && (r_left != 3'd0)) begin
                  w_state_nxt = ST_SNOOZE;
                  w_left_nxt  = r_left - 3'd1;
                  w_cnt_nxt   = 16'd0;
               end
`endif
               else if (bus.tick_1hz) begin
                  w_beep_nxt = ~r_beep;
                  if (r_cnt == RING_LAST) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_RINGING;
               end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
               if (w_stop_edge) begin
                  w_state_nxt = ST_DONE;
               end else if (bus.tick_1hz) begin
                  if (r_cnt == SNOOZE_LAST) begin
                     w_state_nxt = ST_RINGING;
                     w_cnt_nxt   = 16'd0;
                     w_beep_nxt  = 1'b1;
                  end else begin
                     w_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_SNOOZE;
               end
            end
`endif
            ST_DONE: begin
               // Wait for the minute to move on so the same match cannot retrigger
               if (!w_match) begin
                  w_state_nxt = ST_ARMED;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, button history and registered status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_stop_d   <= 1'b0;
         r_beep     <= 1'b0;
         r_cnt      <= 16'd0;
         r_left     <= 3'd0;
         r_ringing  <= 1'b0;
         r_buzzer   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         r_snooze_d <= 1'b0;
         r_snoozing <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_stop_d   <= bus.stop_btn;
         r_beep     <= w_beep_nxt;
         r_cnt      <= w_cnt_nxt;
         r_left     <= w_left_nxt;
         r_ringing  <= (w_state_nxt == ST_RINGING);
         r_buzzer   <= (w_state_nxt == ST_RINGING) && w_beep_nxt;
`ifdef ALARM_SNOOZE_EN
         r_snooze_d <= bus.snooze_btn;
         r_snoozing <= (w_state_nxt == ST_SNOOZE);
`endif
      end
   end

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// tb_alarm_seq_ctrl: directed scenarios plus a randomized run checked against
// an event-level reference model of the alarm sequencer.
module tb_alarm_seq_ctrl;
   localparam int SNOOZE_MIN     = 1;
   localparam int RING_TIMEOUT_S = 5;
   localparam int MAX_SNOOZE     = 2;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   alarm_seq_ctrl_if bus ();

   alarm_seq_ctrl #(
      .SNOOZE_MIN    (SNOOZE_MIN),
      .RING_TIMEOUT_S(RING_TIMEOUT_S),
      .MAX_SNOOZE    (MAX_SNOOZE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: 0 idle, 1 armed, 2 ringing, 3 snoozing, 4 done
   int m_state, m_left, m_ring_ticks, m_wait;
   bit m_beep, m_prev_stop, m_prev_snz;

   task automatic model_clear();
      m_state = 0; m_left = 0; m_ring_ticks = 0; m_wait = 0;
      m_beep = 1'b0; m_prev_stop = 1'b0; m_prev_snz = 1'b0;
   endtask

   // What the alarm does with the inputs present at the coming clock edge
   task automatic model_step();
      bit stop_e, snz_e, match;
      if (reset) begin
         model_clear();
         return;
      end
      stop_e = bus.stop_btn && !m_prev_stop;
      snz_e  = bus.snooze_btn && !m_prev_snz && SNZ_EN;
      m_prev_stop = bus.stop_btn;
      m_prev_snz  = bus.snooze_btn;
      match = (bus.hrs == bus.alarm_hrs) && (bus.mins == bus.alarm_mins);
      if (!bus.arm) begin
         m_state = 0; m_left = 0;
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (bus.tick_1hz && match) begin
            m_state = 2; m_left = MAX_SNOOZE; m_ring_ticks = 0; m_beep = 1'b1;
         end
      end else if (m_state == 2) begin
         if (stop_e) m_state = 4;
         else if (snz_e && m_left > 0) begin
            m_state = 3; m_left = m_left - 1; m_wait = 0;
         end else if (bus.tick_1hz) begin
            m_ring_ticks = m_ring_ticks + 1;
            m_beep = !m_beep;
            if (m_ring_ticks == RING_TIMEOUT_S) m_state = 4;
         end
      end else if (m_state == 3) begin
         if (stop_e) m_state = 4;
         else if (bus.tick_1hz) begin
            m_wait = m_wait + 1;
            if (m_wait == SNOOZE_MIN * 60) begin
               m_state = 2; m_ring_ticks = 0; m_beep = 1'b1;
            end
         end
      end else if (m_state == 4) begin
         if (!match) m_state = 1;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_defaults();
      bus.tick_1hz = 1'b0; bus.hrs = 6'd7; bus.mins = 6'd29; bus.secs = 6'd0;
      bus.alarm_hrs = 6'd7; bus.alarm_mins = 6'd30; bus.arm = 1'b0;
      bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_defaults();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic give_tick();
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      step();
   endtask

   // Arm with setpoint 07:30 and reach 07:30:00 on a tick
   task automatic trigger_ring();
      bus.arm = 1'b1; bus.mins = 6'd29; bus.secs = 6'd59;
      step();
      step();
      bus.mins = 6'd30; bus.secs = 6'd0; bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
   endtask

   task automatic test_reset();
      drive_defaults();
      step();
      step();
      n_total++; if (bus.state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", bus.state); else n_pass++;
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL reset_ringing: got %b expected 0", bus.ringing); else n_pass++;
      n_total++; if (bus.buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b expected 0", bus.buzzer); else n_pass++;
      n_total++; if (bus.snoozing !== 1'b0) $display("FAIL reset_snoozing: got %b expected 0", bus.snoozing); else n_pass++;
      n_total++; if (bus.snooze_left !== 3'd0) $display("FAIL reset_left: got %0d expected 0", bus.snooze_left); else n_pass++;
      reset = 1'b0;
      bus.arm = 1'b1;
      step();
      n_total++; if (bus.state !== 3'd1) $display("FAIL release_armed: got %0d expected 1", bus.state); else n_pass++;
   endtask

   task automatic test_ring_timeout();
      do_reset();
      trigger_ring();
      n_total++; if (bus.state !== 3'd2) $display("FAIL ring_state: got %0d expected 2", bus.state); else n_pass++;
      n_total++; if (bus.ringing !== 1'b1) $display("FAIL ring_ringing: got %b expected 1", bus.ringing); else n_pass++;
      n_total++; if (bus.buzzer !== 1'b1) $display("FAIL ring_buzzer0: got %b expected 1", bus.buzzer); else n_pass++;
      n_total++; if (bus.snooze_left !== (SNZ_EN ? 3'd2 : 3'd0)) $display("FAIL ring_left: got %0d expected %0d", bus.snooze_left, SNZ_EN ? 2 : 0); else n_pass++;
      for (int k = 1; k < RING_TIMEOUT_S; k++) begin
         give_tick();
         n_total++; if (bus.buzzer !== ((k % 2) == 0)) $display("FAIL ring_beep_tick%0d: got %b expected %b", k, bus.buzzer, (k % 2) == 0); else n_pass++;
         n_total++; if (bus.state !== 3'd2) $display("FAIL ring_hold_tick%0d: got %0d expected 2", k, bus.state); else n_pass++;
      end
      give_tick();
      n_total++; if (bus.state !== 3'd4) $display("FAIL timeout_done: got %0d expected 4", bus.state); else n_pass++;
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL timeout_ringing: got %b expected 0", bus.ringing); else n_pass++;
      give_tick();
      n_total++; if (bus.state !== 3'd4) $display("FAIL done_same_minute: got %0d expected 4", bus.state); else n_pass++;
      bus.mins = 6'd31;
      step();
      n_total++; if (bus.state !== 3'd1) $display("FAIL done_rearm: got %0d expected 1", bus.state); else n_pass++;
   endtask

`ifdef ALARM_SNOOZE_EN
   task automatic test_snooze();
      do_reset();
      trigger_ring();
      bus.snooze_btn = 1'b1;
      step();
      n_total++; if (bus.state !== 3'd3) $display("FAIL snz1_state: got %0d expected 3", bus.state); else n_pass++;
      n_total++; if (bus.snooze_left !== 3'd1) $display("FAIL snz1_left: got %0d expected 1", bus.snooze_left); else n_pass++;
      n_total++; if (bus.snoozing !== 1'b1) $display("FAIL snz1_snoozing: got %b expected 1", bus.snoozing); else n_pass++;
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL snz1_ringing: got %b expected 0", bus.ringing); else n_pass++;
      // Button stays held through the interval: a held level must not retrigger
      for (int k = 1; k < SNOOZE_MIN * 60; k++) give_tick();
      n_total++; if (bus.state !== 3'd3) $display("FAIL snz1_wait: got %0d expected 3", bus.state); else n_pass++;
      give_tick();
      n_total++; if (bus.state !== 3'd2) $display("FAIL snz1_rering: got %0d expected 2", bus.state); else n_pass++;
      n_total++; if (bus.buzzer !== 1'b1) $display("FAIL snz1_rering_buzz: got %b expected 1", bus.buzzer); else n_pass++;
      bus.snooze_btn = 1'b0;
      step();
      bus.snooze_btn = 1'b1;
      step();
      n_total++; if (bus.snooze_left !== 3'd0) $display("FAIL snz2_left: got %0d expected 0", bus.snooze_left); else n_pass++;
      bus.snooze_btn = 1'b0;
      for (int k = 0; k < SNOOZE_MIN * 60; k++) give_tick();
      n_total++; if (bus.state !== 3'd2) $display("FAIL snz2_rering: got %0d expected 2", bus.state); else n_pass++;
      bus.snooze_btn = 1'b1;
      step();
      bus.snooze_btn = 1'b0;
      n_total++; if (bus.state !== 3'd2) $display("FAIL snz_exhausted: got %0d expected 2", bus.state); else n_pass++;
      for (int k = 0; k < RING_TIMEOUT_S; k++) give_tick();
      n_total++; if (bus.state !== 3'd4) $display("FAIL rering_timeout: got %0d expected 4", bus.state); else n_pass++;
   endtask
`else
   task automatic test_snooze_disabled();
      do_reset();
      trigger_ring();
      bus.snooze_btn = 1'b1;
      step();
      bus.snooze_btn = 1'b0;
      n_total++; if (bus.state !== 3'd2) $display("FAIL nosnz_state: got %0d expected 2", bus.state); else n_pass++;
      n_total++; if (bus.snoozing !== 1'b0) $display("FAIL nosnz_snoozing: got %b expected 0", bus.snoozing); else n_pass++;
      n_total++; if (bus.snooze_left !== 3'd0) $display("FAIL nosnz_left: got %0d expected 0", bus.snooze_left); else n_pass++;
   endtask
`endif

   task automatic test_stop_and_snooze();
      do_reset();
      trigger_ring();
      bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
      step();
      bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
      n_total++; if (bus.state !== 3'd4) $display("FAIL both_state: got %0d expected 4", bus.state); else n_pass++;
      n_total++; if (bus.snooze_left !== (SNZ_EN ? 3'd2 : 3'd0)) $display("FAIL both_left: got %0d expected %0d", bus.snooze_left, SNZ_EN ? 2 : 0); else n_pass++;
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL both_ringing: got %b expected 0", bus.ringing); else n_pass++;
   endtask

   task automatic test_arm_drop();
      do_reset();
      trigger_ring();
      bus.snooze_btn = 1'b1;
      step();
      bus.snooze_btn = 1'b0;
      bus.arm = 1'b0;
      step();
      n_total++; if (bus.state !== 3'd0) $display("FAIL disarm_state: got %0d expected 0", bus.state); else n_pass++;
      n_total++; if (bus.snoozing !== 1'b0) $display("FAIL disarm_snoozing: got %b expected 0", bus.snoozing); else n_pass++;
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL disarm_ringing: got %b expected 0", bus.ringing); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      trigger_ring();
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      n_total++; if (bus.ringing !== 1'b0) $display("FAIL async_ringing: got %b expected 0", bus.ringing); else n_pass++;
      n_total++; if (bus.state !== 3'd0) $display("FAIL async_state: got %0d expected 0", bus.state); else n_pass++;
      step();
      reset = 1'b0;
      step();
      n_total++; if (bus.state !== 3'd1) $display("FAIL async_rearm: got %0d expected 1", bus.state); else n_pass++;
      bus.mins = 6'd31;
      give_tick();
      give_tick();
      n_total++; if (bus.state !== 3'd1) $display("FAIL async_noretrig: got %0d expected 1", bus.state); else n_pass++;
      bus.mins = 6'd30; bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      n_total++; if (bus.state !== 3'd2) $display("FAIL async_next_match: got %0d expected 2", bus.state); else n_pass++;
   endtask

   task automatic test_random();
      bit exp_ring, exp_buzz, exp_snz;
      logic [2:0] exp_left;
      do_reset();
      bus.arm = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         bus.tick_1hz = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 49) == 0) bus.mins = 6'($urandom_range(29, 31));
         if ($urandom_range(0, 99) == 0) bus.alarm_mins = 6'($urandom_range(30, 31));
         if ($urandom_range(0, 149) == 0) bus.stop_btn = ~bus.stop_btn;
         if ($urandom_range(0, 11) == 0) bus.snooze_btn = ~bus.snooze_btn;
         bus.arm  = ($urandom_range(0, 399) != 0);
         bus.secs = 6'($urandom_range(0, 59));
         step();
         exp_ring = (m_state == 2);
         exp_buzz = exp_ring && m_beep;
         exp_snz  = (m_state == 3);
         exp_left = SNZ_EN ? 3'(m_left) : 3'd0;
         n_total++; if (bus.state !== 3'(m_state)) $display("FAIL rnd_state cyc %0d: got %0d expected %0d", i, bus.state, m_state); else n_pass++;
         n_total++; if (bus.ringing !== exp_ring) $display("FAIL rnd_ringing cyc %0d: got %b expected %b", i, bus.ringing, exp_ring); else n_pass++;
         n_total++; if (bus.buzzer !== exp_buzz) $display("FAIL rnd_buzzer cyc %0d: got %b expected %b", i, bus.buzzer, exp_buzz); else n_pass++;
         n_total++; if (bus.snoozing !== exp_snz) $display("FAIL rnd_snoozing cyc %0d: got %b expected %b", i, bus.snoozing, exp_snz); else n_pass++;
         n_total++; if (bus.snooze_left !== exp_left) $display("FAIL rnd_left cyc %0d: got %0d expected %0d", i, bus.snooze_left, exp_left); else n_pass++;
      end
   endtask

   initial begin
      model_clear();
      drive_defaults();
      test_reset();
      test_ring_timeout();
`ifdef ALARM_SNOOZE_EN
      test_snooze();
`else
      test_snooze_disabled();
`endif
      test_stop_and_snooze();
      test_arm_drop();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
